// File: rtl/core101_pkg.sv
// core101_pkg: shared constants and types for the core101 memory-side blocks.
// Holds the default data width, the responder FSM states and the wait-counter width.
package core101_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int WCNT_W       = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    function automatic logic [WCNT_W-1:0] wait_load(input int cycles);
        return WCNT_W'(cycles);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: single-port DEPTH x XLEN storage with synchronous write and read.
// Read data is registered and holds until the next read enable; only that register is reset.
module data_mem_array
    import core101_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic                     re,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word-addressed data memory slave (IDLE/WAIT/RESP).
// Define DATA_MEM_ALIGN_CHECK_EN to flag misaligned or out-of-range addresses as errors.
module data_mem_responder
    import core101_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            data_mem_valid_in,
    input  logic            data_mem_write_in,
    input  logic [XLEN-1:0] data_mem_addr_in,
    input  logic [XLEN-1:0] data_mem_data_in,
    output logic [XLEN-1:0] data_mem_data_out,
    output logic            data_mem_ready_out,
    output logic            data_mem_error_out
);

    localparam int IDXW = $clog2(DEPTH);

    state_t            state;
    logic [WCNT_W-1:0] cnt;
    logic              lat_write;
    logic              lat_err;
    logic [IDXW-1:0]   lat_idx;
    logic [XLEN-1:0]   lat_data;

    logic              req_err;
    logic              go_resp;
    logic              acc_write;
    logic              acc_err;
    logic [IDXW-1:0]   acc_idx;
    logic [XLEN-1:0]   acc_data;
    logic              mem_we;
    logic              mem_re;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign req_err = (data_mem_addr_in[1:0] != 2'b00) ||
                     ((data_mem_addr_in >> (IDXW + 2)) != '0);
`else
    // Byte offset and bits above the word index are ignored: the index wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_mem_addr_in[XLEN-1:IDXW+2], data_mem_addr_in[1:0]};
    assign req_err = 1'b0;
`endif

    // With zero wait states the access fires straight from IDLE, so the array
    // must see the live request rather than the copy latched on that same edge.
    always_comb begin
        go_resp   = 1'b0;
        acc_write = lat_write;
        acc_err   = lat_err;
        acc_idx   = lat_idx;
        acc_data  = lat_data;
        case (state)
            S_IDLE: begin
                acc_write = data_mem_write_in;
                acc_err   = req_err;
                acc_idx   = data_mem_addr_in[IDXW+1:2];
                acc_data  = data_mem_data_in;
                go_resp   = data_mem_valid_in && (WAIT_CYCLES == 0);
            end
            S_WAIT:  go_resp = data_mem_valid_in && (cnt == WCNT_W'(1));
            default: go_resp = 1'b0;
        endcase
    end

    assign mem_we = go_resp && acc_write && !acc_err && !reset_in;
    assign mem_re = go_resp && !acc_write && !acc_err && !reset_in;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state              <= S_IDLE;
            cnt                <= '0;
            lat_write          <= 1'b0;
            lat_err            <= 1'b0;
            lat_idx            <= '0;
            lat_data           <= '0;
            data_mem_ready_out <= 1'b0;
            data_mem_error_out <= 1'b0;
        end else begin
            data_mem_ready_out <= go_resp;
            data_mem_error_out <= go_resp && acc_err;
            case (state)
                S_IDLE: begin
                    if (data_mem_valid_in) begin
                        lat_write <= data_mem_write_in;
                        lat_err   <= req_err;
                        lat_idx   <= data_mem_addr_in[IDXW+1:2];
                        lat_data  <= data_mem_data_in;
                        cnt       <= wait_load(WAIT_CYCLES);
                        state     <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!data_mem_valid_in) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == WCNT_W'(1)) begin
                        state <= S_RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - WCNT_W'(1);
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    data_mem_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clock_in),
        .rst   (reset_in),
        .addr  (acc_idx),
        .we    (mem_we),
        .re    (mem_re),
        .wdata (acc_data),
        .rdata (data_mem_data_out)
    );

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter DEPTH, default 1024, number of XLEN-bit words of storage; power of two.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, added access wait states.
REQ-004 SHALL have port clock_in, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_in, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port data_mem_valid_in, input, 1, initiator request.
REQ-007 SHALL have port data_mem_write_in, input, 1, 1=write, 0=read.
REQ-008 SHALL have port data_mem_addr_in, input, XLEN, byte address.
REQ-009 SHALL have port data_mem_data_in, input, XLEN, write data.
REQ-010 SHALL have port data_mem_data_out, output, XLEN, read data.
REQ-011 SHALL have port data_mem_ready_out, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port data_mem_error_out, output, 1, error flag, qualified by ready.

Function
REQ-013 SHALL implement FSM IDLE, WAIT, RESP.
REQ-014 IDLE: valid=1 latches write, addr[log2(DEPTH)+1:2], data; loads wait counter with WAIT_CYCLES; goes to WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 WAIT: counter decrements each cycle; at 1 goes to RESP.
REQ-016 RESP: ready_out=1 for exactly one cycle; next state IDLE unconditionally.
REQ-017 Latency: valid sampled high at edge t, ready_out high in cycle t+1+WAIT_CYCLES.
REQ-018 Write SHALL commit to the array on the edge entering RESP; reads load data_out on that same edge.
REQ-019 data_out SHALL hold the last read value until the next completed read; writes leave it unchanged.
REQ-020 Initiator holds valid/addr/write/data stable until ready; if valid drops in WAIT, FSM returns to IDLE, no write, no ready pulse.
REQ-021 Valid held high through RESP SHALL start a new request in the following IDLE cycle (back-to-back throughput 1 per 2+WAIT_CYCLES cycles).
REQ-022 Inputs changing after latch in WAIT SHALL NOT affect the pending access (latched copy used).

Reset
REQ-023 Reset SHALL force IDLE, counter 0, ready_out 0, error_out 0, data_out 0.
REQ-024 Reset mid-operation SHALL abort with no write and no ready pulse; array contents not reset.

Configuration
REQ-025 Macro DATA_MEM_ALIGN_CHECK_EN defined: addr[1:0]!=0 or addr >= 4*DEPTH completes with normal latency, ready_out=1, error_out=1, no write, data_out unchanged.
REQ-026 Macro undefined: addr[1:0] ignored, word index wraps modulo DEPTH, error_out tied 0.

Structure
REQ-027 Shared package core101_pkg SHALL hold XLEN default, FSM state typedef, and wait-counter width constant (4).
REQ-028 Storage SHALL be sub-module data_mem_array: single-port, synchronous write, synchronous read, DEPTH x XLEN.

Verification
REQ-029 Write 0xDEADBEEF to 0x10, WAIT_CYCLES=1 -> ready at cycle t+2; read 0x10 -> data_out=0xDEADBEEF, error=0.
REQ-030 WAIT_CYCLES=0, back-to-back reads 0x0,0x4 with valid held -> ready pulses 2 cycles apart, each one cycle wide.
REQ-031 Read 0x20 then write 0x24 -> data_out keeps read value after write ready.
REQ-032 Valid deasserted in WAIT (WAIT_CYCLES=3) on a write to 0x8 -> no ready; later read 0x8 returns prior contents.
REQ-033 Reset asserted in WAIT on a write -> outputs 0 immediately, location unchanged.
REQ-034 With DATA_MEM_ALIGN_CHECK_EN, write to 0x6 -> ready=1, error=1, memory unchanged; without, DEPTH=1024 address 0x1004 aliases 0x4.
